pattern_detector_param: RTL and testbench

Parametrised serial pattern detector. Successor to the fixed single-pattern detector. Samples a 1-bit stream on `valid` and compares the most recent N bits against a run-time programmable pattern of programmable length. Adds overlapping/non-overlapping match modes and a saturating match counter. Sits on the serial-input datapath, feeding event/status logic.

---
 rtl/pd_pkg.sv | 26 ++
 rtl/pd_sat_counter.sv | 31 +++
 rtl/pattern_detector_param.sv | 82 ++++++++
 tb/tb_pattern_detector_param.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pd_pkg.sv
// Shared types, defaults and helpers for the parametrised pattern detector.
package pd_pkg;

   localparam int MAX_W = 64;
   localparam logic [7:0] DEF_PAT_C = 8'b0000_1011;
   localparam int DEF_LEN_C = 4;

   function automatic int len_w(int pat_w);
      return $clog2(pat_w + 1);
   endfunction

   function automatic int clamp_len(int len, int pat_w);
      if (len < 1) return 1;
      if (len > pat_w) return pat_w;
      return len;
   endfunction

   function automatic logic [MAX_W-1:0] len_mask(int len);
      logic [MAX_W-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_W; i++)
         m[i] = (i < len);
      return m;
   endfunction

endpackage

// File: rtl/pd_sat_counter.sv
// Saturating counter; a clear coincident with an increment yields one.
module pd_sat_counter
   import pd_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = inc ? W'(1) : '0;
      else if (inc && (cnt_q != '1))
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pattern_detector_param.sv
// Serial pattern detector with programmable pattern, length and overlap mode.
module pattern_detector_param
   import pd_pkg::*;
#(
   parameter int PAT_W = 8,
   parameter int CNT_W = 16,
   parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_C),
   parameter int DEF_LEN = DEF_LEN_C,
   localparam int LEN_W = len_w(PAT_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic             in,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pat,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_ovl,
   input  logic             cnt_clr,
   output logic             out,
   output logic [CNT_W-1:0] match_cnt,
   output logic [LEN_W-1:0] cur_len
);

   logic [PAT_W-2:0] hist_q;
   logic [LEN_W-1:0] fill_q, len_q;
   logic [PAT_W-1:0] pat_q;
   logic             ovl_q, out_q;

   logic [PAT_W-1:0] cand, mask;
   logic [MAX_W-1:0] mask_full;
   logic             unused_mask;
   logic             filled, hit;

   assign cand      = {hist_q, in};
   assign mask_full = len_mask(int'(len_q));
   assign mask      = mask_full[PAT_W-1:0];
   assign unused_mask = ^mask_full[MAX_W-1:PAT_W];

   assign filled = ((LEN_W+1)'(fill_q) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);
   assign hit = valid & ~cfg_load & filled & (((cand ^ pat_q) & mask) == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q <= '0;
         fill_q <= '0;
         pat_q  <= DEF_PAT;
         len_q  <= LEN_W'(DEF_LEN);
         ovl_q  <= 1'b1;
         out_q  <= 1'b0;
      end else if (cfg_load) begin
         pat_q  <= cfg_pat;
         len_q  <= LEN_W'(clamp_len(int'(cfg_len), PAT_W));
         ovl_q  <= cfg_ovl;
         hist_q <= '0;
         fill_q <= '0;
         out_q  <= 1'b0;
      end else if (valid) begin
         hist_q <= cand[PAT_W-2:0];
         out_q  <= hit;
         // Non-overlap mode restarts the fill so the next match needs fresh bits
         if (hit && !ovl_q)
            fill_q <= '0;
         else if (fill_q != LEN_W'(PAT_W))
            fill_q <= fill_q + LEN_W'(1);
      end else begin
         out_q <= 1'b0;
      end
   end

   pd_sat_counter #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (hit),
      .cnt (match_cnt)
   );

   assign out     = out_q;
   assign cur_len = len_q;

endmodule

// File: tb/tb_pattern_detector_param.sv
// Directed table-driven bench for pattern_detector_param.
module tb_pattern_detector_param;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic valid = 1'b0, in = 1'b0, cfg_load = 1'b0, cfg_ovl = 1'b1, cnt_clr = 1'b0;
   logic [7:0] cfg_pat = 8'h0B;
   logic [3:0] cfg_len = 4'd4;
   logic out, out3;
   logic [15:0] match_cnt;
   logic [2:0] cnt3;
   logic [3:0] cur_len, len3;

   int nchk = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   pattern_detector_param dut (
      .clk(clk), .rst(rst), .valid(valid), .in(in), .cfg_load(cfg_load),
      .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
      .out(out), .match_cnt(match_cnt), .cur_len(cur_len)
   );

   pattern_detector_param #(.CNT_W(3)) dut3 (
      .clk(clk), .rst(rst), .valid(valid), .in(in), .cfg_load(cfg_load),
      .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
      .out(out3), .match_cnt(cnt3), .cur_len(len3)
   );

   typedef struct {
      logic       v, b, ld, clr, ovl;
      logic [7:0] pat;
      logic [3:0] len;
      logic       eo;
      int         ecnt, elen;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(logic v, logic b, logic ld, logic clr,
                               logic [7:0] pat, logic [3:0] len, logic ovl,
                               logic eo, int ecnt, int elen);
      vec_t t;
      t.v = v; t.b = b; t.ld = ld; t.clr = clr; t.pat = pat;
      t.len = len; t.ovl = ovl; t.eo = eo; t.ecnt = ecnt; t.elen = elen;
      tbl.push_back(t);
   endfunction

   task automatic chk(string name, int act, int exp);
      nchk++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(logic v, logic b, logic ld, logic clr,
                        logic [7:0] pat, logic [3:0] len, logic ovl);
      valid = v; in = b; cfg_load = ld; cnt_clr = clr;
      cfg_pat = pat; cfg_len = len; cfg_ovl = ovl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 8'h0B, 4'd4, 1);
   endtask

   // One serial bit with no config change
   task automatic bit_in(logic b, logic eo, string name);
      drive(1, b, 0, 0, 8'h0B, 4'd4, 1);
      tick();
      chk(name, int'(out), int'(eo));
   endtask

   initial begin
      // Section 1: defaults, overlap
      add(1,1,0,0,8'h0B,4,1, 0,0,4);
      add(1,0,0,0,8'h0B,4,1, 0,0,4);
      add(1,1,0,0,8'h0B,4,1, 0,0,4);
      add(1,1,0,0,8'h0B,4,1, 1,1,4);
      add(1,0,0,0,8'h0B,4,1, 0,1,4);
      add(1,1,0,0,8'h0B,4,1, 0,1,4);
      add(1,1,0,0,8'h0B,4,1, 1,2,4);
      // Section 2: non-overlap
      add(0,0,1,1,8'h0B,4,0, 0,0,4);
      add(1,1,0,0,8'h0B,4,0, 0,0,4);
      add(1,0,0,0,8'h0B,4,0, 0,0,4);
      add(1,1,0,0,8'h0B,4,0, 0,0,4);
      add(1,1,0,0,8'h0B,4,0, 1,1,4);
      add(1,0,0,0,8'h0B,4,0, 0,1,4);
      add(1,1,0,0,8'h0B,4,0, 0,1,4);
      add(1,1,0,0,8'h0B,4,0, 0,1,4);
      // Section 3: valid gap, then load with a bit present
      add(0,0,1,1,8'h0B,4,1, 0,0,4);
      add(1,1,0,0,8'h0B,4,1, 0,0,4);
      add(1,0,0,0,8'h0B,4,1, 0,0,4);
      for (int i = 0; i < 5; i++)
         add(0,1,0,0,8'h0B,4,1, 0,0,4);
      add(1,1,0,0,8'h0B,4,1, 0,0,4);
      add(1,1,0,0,8'h0B,4,1, 1,1,4);
      add(1,1,1,0,8'h0B,4,1, 0,1,4);
      add(1,0,0,0,8'h0B,4,1, 0,1,4);
      add(1,1,0,0,8'h0B,4,1, 0,1,4);
      add(1,1,0,0,8'h0B,4,1, 0,1,4);
      // Section 4: full-width pattern, then clamping
      add(0,0,1,1,8'hA5,8,1, 0,0,8);
      add(1,1,0,0,8'hA5,8,1, 0,0,8);
      add(1,0,0,0,8'hA5,8,1, 0,0,8);
      add(1,1,0,0,8'hA5,8,1, 0,0,8);
      add(1,0,0,0,8'hA5,8,1, 0,0,8);
      add(1,0,0,0,8'hA5,8,1, 0,0,8);
      add(1,1,0,0,8'hA5,8,1, 0,0,8);
      add(1,0,0,0,8'hA5,8,1, 0,0,8);
      add(1,1,0,0,8'hA5,8,1, 1,1,8);
      add(0,0,1,0,8'hFD,0,1, 0,1,1);
      add(1,1,0,0,8'hFD,0,1, 1,2,1);
      add(1,0,0,0,8'hFD,0,1, 0,2,1);
      add(1,1,0,0,8'hFD,0,1, 1,3,1);
      add(1,1,0,0,8'hFD,0,1, 1,4,1);
      add(0,0,1,0,8'h0B,12,1, 0,4,8);

      rst = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out", int'(out), 0);
      chk("reset_cnt", int'(match_cnt), 0);
      chk("reset_len", int'(cur_len), 4);
      rst = 1'b1;
      tick();

      foreach (tbl[k]) begin
         drive(tbl[k].v, tbl[k].b, tbl[k].ld, tbl[k].clr,
               tbl[k].pat, tbl[k].len, tbl[k].ovl);
         tick();
         chk($sformatf("vec%0d_out", k), int'(out), int'(tbl[k].eo));
         chk($sformatf("vec%0d_cnt", k), int'(match_cnt), tbl[k].ecnt);
         chk($sformatf("vec%0d_len", k), int'(cur_len), tbl[k].elen);
      end

      // Section 5: 3-bit counter saturation and clear-then-count
      drive(0, 0, 1, 1, 8'h01, 4'd1, 1);
      tick();
      chk("sat_start", int'(cnt3), 0);
      for (int i = 0; i < 9; i++) begin
         drive(1, 1, 0, 0, 8'h01, 4'd1, 1);
         tick();
         chk($sformatf("sat_out%0d", i), int'(out3), 1);
         chk($sformatf("sat_cnt%0d", i), int'(cnt3), (i + 1 > 7) ? 7 : i + 1);
      end
      drive(1, 1, 0, 1, 8'h01, 4'd1, 1);
      tick();
      chk("clr_hit_cnt", int'(cnt3), 1);
      drive(0, 0, 0, 1, 8'h01, 4'd1, 1);
      tick();
      chk("clr_only_cnt", int'(cnt3), 0);
      chk("clr_only_cnt16", int'(match_cnt), 0);

      // Section 6: asynchronous reset mid-pattern
      drive(0, 0, 1, 1, 8'h0B, 4'd4, 1);
      tick();
      bit_in(1, 0, "rs_a0");
      bit_in(0, 0, "rs_a1");
      bit_in(1, 0, "rs_a2");
      bit_in(1, 1, "rs_a3");
      rst = 1'b0;
      #1;
      chk("async_out", int'(out), 0);
      chk("async_cnt", int'(match_cnt), 0);
      idle();
      tick();
      rst = 1'b1;
      bit_in(1, 0, "rs_b0");
      bit_in(0, 0, "rs_b1");
      bit_in(1, 0, "rs_b2");
      rst = 1'b0;
      #1;
      chk("async_out2", int'(out), 0);
      idle();
      tick();
      rst = 1'b1;
      bit_in(1, 0, "rs_post0");
      bit_in(0, 0, "rs_post1");
      bit_in(1, 0, "rs_post2");
      bit_in(1, 1, "rs_post3");
      chk("rs_post_cnt", int'(match_cnt), 1);
      idle();
      tick();
      chk("pulse_width", int'(out), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
